uart_rx_ctrl: RTL and testbench

UART receiver for the Arty echo path: 8-N-1 serial input on the board RX pin, byte output with valid/ack handshake.
- Feeds the character-send logic, which forwards received bytes to the UART transmit controller for echo.
- Upstream neighbour of the send/ready/data interface on the transmit side.
- One clock domain (100 MHz board clock); the asynchronous serial input is synchronised internally.

---
 rtl/uart_rx_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8-N-1 UART receiver with valid/ack byte handshake and error pulses.
// Define UART_RX_PARITY_EN for 8-E-1 frames with parity checking.
module uart_rx_ctrl #(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD        = 9600,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int TW          = $clog2(BIT_CYCLES) + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   brk_q, brk_d;
  logic [7:0]             rx_data_q;
  logic                   rx_valid_q, frame_err_q, overrun_q, parity_err_q;
  logic                   rxs, load, ferr, perr, tick;
  assign rxs  = sync_q[SYNC_STAGES-1];
  assign tick = (timer_q == BIT_LAST);
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) par_q <= 1'b0;
    else        par_q <= par_d;
`endif
  always_comb begin
    state_d = state_q;
    timer_d = tick ? timer_q : timer_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    load    = 1'b0;
    ferr    = 1'b0;
    perr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        // after a framing error, wait for the line to return high before re-arming
        if (brk_q) brk_d = ~rxs;
        else if (!rxs) state_d = START;
      end
      START: if (timer_q == HALF_LAST) begin
        state_d = rxs ? IDLE : DATA;
        timer_d = '0;
        idx_d   = 3'd0;
      end
      DATA: if (tick) begin
        shift_d[idx_q] = rxs;
        timer_d        = '0;
        idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_d   = rxs;
        timer_d = '0;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        state_d = IDLE;
        timer_d = '0;
        ferr    = ~rxs;
        brk_d   = ~rxs;
`ifdef UART_RX_PARITY_EN
        perr    = rxs & (par_q != ^shift_q);
        load    = rxs & ~perr;
`else
        load    = rxs;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      sync_q       <= '1;
      timer_q      <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      brk_q        <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], UART_RX};
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      brk_q        <= brk_d;
      rx_data_q    <= load ? shift_q : rx_data_q;
      rx_valid_q   <= load | (rx_valid_q & ~rx_ack);
      frame_err_q  <= ferr;
      overrun_q    <= load & rx_valid_q & ~rx_ack;
      parity_err_q <= perr;
    end
  end
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized frames checked against a frame-level model.
// Build with UART_RX_PARITY_EN defined to exercise 8-E-1 frames.
module tb_uart_rx_ctrl;
  localparam int BIT  = 16;
  localparam int HALF = 8;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // cycle index (from start-bit drive) of the edge that samples the stop bit
  localparam int DONE = SYNC + 1 + HALF + (NB - 1) * BIT;
  logic       CLK = 0, RST_N = 0, UART_RX = 1, rx_ack = 0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err;
  int total = 0, bad = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0, n_rise = 0;
  int e_ferr = 0, e_ovr = 0, e_perr = 0, e_rise = 0;
  logic [7:0] e_data = 8'h00;
  logic       e_valid = 0, prev_v = 0;
  uart_rx_ctrl #(.CLK_FREQ(1600000), .BAUD(100000), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (parity_err) n_perr++;
    if (rx_valid && !prev_v) n_rise++;
    prev_v = rx_valid;
  end
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".data"}, rx_data, e_data);
    check({tag, ".valid"}, rx_valid, e_valid);
    check({tag, ".ferr"}, n_ferr, e_ferr);
    check({tag, ".ovr"}, n_ovr, e_ovr);
    check({tag, ".perr"}, n_perr, e_perr);
    check({tag, ".rise"}, n_rise, e_rise);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic ack_pulse();
    rx_ack = 1;
    @(negedge CLK);
    rx_ack = 0;
    e_valid = 0;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input logic ack_done);
    logic [10:0] bits;
    bits = {1'b1, 1'b1, 1'b1, b, 1'b0};
`ifdef UART_RX_PARITY_EN
    bits[9]  = par;
    bits[10] = stop;
`else
    bits[9]  = stop;
`endif
    for (int c = 0; c < NB * BIT; c++) begin
      UART_RX = bits[c / BIT];
      rx_ack  = ack_done && (c == DONE - 1);
      @(negedge CLK);
    end
    UART_RX = 1;
    rx_ack  = 0;
`ifdef UART_RX_PARITY_EN
    if (stop && (par != ^b)) begin
      e_perr++;
      if (ack_done) e_valid = 0;
    end else
`endif
    if (!stop) begin
      e_ferr++;
      if (ack_done) e_valid = 0;
    end else begin
      if (e_valid && !ack_done) e_ovr++;
      if (!e_valid) e_rise++;
      e_valid = 1;
      e_data  = b;
    end
    idle(6);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ack_done);
    send_frame(b, 1'b1, ^b, ack_done);
  endtask
  initial begin
    idle(4);
    check("rst.data", rx_data, 0);
    check("rst.valid", rx_valid, 0);
    check("rst.errs", {frame_err, overrun, parity_err}, 0);
    RST_N = 1;
    idle(200);
    check_all("idle");
    send_byte(8'h41, 0);
    check_all("byteA");
    idle(50);
    check_all("hold");
    rx_ack = 1;
    @(negedge CLK);
    rx_ack = 0;
    e_valid = 0;
    check("ack.valid", rx_valid, 0);
    send_byte(8'h52, 0);
    send_byte(8'h54, 0);
    check_all("overrun");
    ack_pulse();
    send_byte(8'h52, 0);
    send_byte(8'h54, 1);
    check_all("ack_at_done");
    ack_pulse();
    UART_RX = 0;
    idle(4);
    UART_RX = 1;
    idle(40);
    check_all("glitch");
    send_frame(8'h59, 1'b0, ^8'h59, 0);
    check_all("frame_err");
    UART_RX = 0;
    idle(40 * BIT);
    UART_RX = 1;
    e_ferr++;
    idle(40);
    check_all("break");
    for (int c = 0; c < 4 * BIT + HALF; c++) begin
      UART_RX = (c < BIT) ? 1'b0 : ((8'h37 >> (c / BIT - 1)) & 1);
      @(negedge CLK);
    end
    RST_N = 0;
    idle(5);
    UART_RX = 1;
    e_valid = 0;
    e_data  = 8'h00;
    check("mid_rst.data", rx_data, 0);
    check("mid_rst.valid", rx_valid, 0);
    RST_N = 1;
    idle(20);
    send_byte(8'h0A, 0);
    check_all("after_rst");
`ifdef UART_RX_PARITY_EN
    ack_pulse();
    send_frame(8'h41, 1'b1, 1'b0, 0);
    check_all("par_ok");
    ack_pulse();
    send_frame(8'h41, 1'b1, 1'b1, 0);
    check_all("par_bad");
    send_frame(8'h41, 1'b0, 1'b1, 0);
    check_all("par_bad_stop");
`endif
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 2) == 0) ack_pulse();
      send_frame(b, $urandom_range(0, 4) != 0, ($urandom_range(0, 4) != 0) ? ^b : ~^b,
                 1'($urandom_range(0, 3) == 0));
      check_all("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
